connection_block_cfg: RTL and testbench
=======================================

// Module: connection_block_cfg
// PURPOSE
// - Next-generation FPGA connection block: joins two neighbouring CLBs to single, double and global routing tracks.
// - Replaces bidirectional pass gates with directional muxes and enables, so the block is synthesizable.
// - Holds its own configuration: a serial shadow chain, then an atomic commit into the active config.
// - Sits between two CLB tiles on a channel; the switch box resolves the track drive/enable pairs.
// PARAMETERS
// - WS          8  single tracks
// - WD          8  double tracks, even; only the lower WD/2 are drivable by CLBs
// - WG          3  global lines
// - CLBIN       6  inputs per CLB (both CLBs)
// - CLBOUT      1  outputs per CLB (both CLBs)
// - CLBOS       2  single tracks each CLB output can drive
// - CLBOD       2  double tracks each CLB output can drive
// - CLBOS_BIAS  0  rotation offset of the output->single assignment
// - CLBOD_BIAS  0  rotation offset of the output->double assignment
// - CLBX        1  1 = each CLB's outputs are direct sources for the other CLB's inputs
// - derived     N_IN=WS+WD+WG+CLBX*CLBOUT; SEL_W=clog2(N_IN+1); SPO=CLBOS+CLBOD
// - derived     HALF=CLBIN*SEL_W+CLBOUT*SPO; CFG_LEN=2*HALF
// PORTS
// - clk          in   1       clock
// - rst          in   1       asynchronous active-high reset
// - cfg_start    in   1       begin a new load; clears the bit counter
// - cfg_valid    in   1       shift cfg_in into the shadow chain this cycle
// - cfg_in       in   1       serial config bit
// - cfg_commit   in   1       copy shadow into active config
// - cfg_out      out  1       shadow[CFG_LEN-1], for chaining and readback
// - cfg_ready    out  1       shadow fully loaded (state READY)
// - cfg_done     out  1       one-cycle pulse after a commit
// - cfg_err      out  1       sticky protocol error
// - single_in    in   WS      single track values
// - double_in    in   WD      double track values
// - global       in   WG      global lines
// - clb0_output, clb1_output  in   CLBOUT  CLB outputs
// - clb0_cout, clb1_cout      in   1       carry outputs
// - clb0_input, clb1_input    out  CLBIN   CLB inputs
// - clb0_cin, clb1_cin        out  1       carry inputs
// - single_drv   out  WS      value driven onto each single track
// - single_oe    out  WS      drive enable per single track
// - double_drv   out  WD      value driven onto each double track
// - double_oe    out  WD      drive enable per double track; bits >= WD/2 always 0
// BEHAVIOUR
// - Reset: shadow, active config and counter are 0; FSM goes to IDLE; cfg_ready, cfg_done and cfg_err are 0.
//   - All CLB inputs are then 0 and all oe bits are 0; cfg_out is 0.
// - Shift: on cfg_valid in IDLE or LOAD, shadow <= {shadow[CFG_LEN-2:0], cfg_in}. cfg_out is registered.
// - FSM transitions:
//   - IDLE -> LOAD on cfg_start, counter=0. cfg_start has priority over a same-cycle cfg_valid; that bit is dropped.
//   - LOAD: each cfg_valid increments the counter. The shift that brings the counter to CFG_LEN moves to READY.
//   - READY + cfg_commit: active <= shadow; cfg_done is high the next cycle; go to IDLE.
//   - cfg_commit outside READY: ignored, cfg_err set.
//   - cfg_valid in READY: shift suppressed, cfg_err set.
//   - cfg_start in any state: restart LOAD; cfg_err is unchanged.
//   - cfg_err clears only on rst.
// - The active config changes only at a commit. The datapath never sees a partly loaded shadow.
// - Config layout, per side s (s=0 at base 0, s=1 at base HALF):
//   - input i selector is at [base+i*SEL_W +: SEL_W]
//   - output k enables are at [base+CLBIN*SEL_W+k*SPO +: SPO]; singles b<CLBOS first, then doubles
// - Input mux: code 0 gives 0. Code c in 1..N_IN gives source c-1, in the order singles, doubles, globals, other CLB's outputs.
//   - Code > N_IN gives 0. The mux is combinational from the active config.
// - Output enable for side s, output k, single bit b:
//   - it drives single track (((s*CLBOUT+k)*CLBOS + b + CLBOS_BIAS*CLBOS*2*CLBOUT) % WS)
//   - doubles use the same rule with CLBOD, modulo WD/2
// - Multiple drivers on one track: oe is the OR of the enables. drv takes the lowest (s,k) enabled source, clb0 before clb1.
//   - drv is 0 when oe is 0.
// - Carry: clb1_cin = clb0_cout and clb0_cin = clb1_cout, both combinational.
// - Reset mid-load drops the shadow contents; the active config returns to 0.
// STRUCTURE
// - Shared header cb_params.vh: clog2 function, N_IN/SEL_W/SPO/HALF/CFG_LEN macros, FSM state encodings IDLE=0, LOAD=1, READY=2.
// - One sub-module, cb_input_mux (N_IN, SEL_W): source vector plus selector in, one bit out. It is instantiated 2*CLBIN times.
// - Track-enable rotation and conflict resolution go in generate loops in this module.
// TESTING
// - Defaults give N_IN=20, SEL_W=5, CFG_LEN=68.
// - Reset: assert rst mid-shift -> every output is 0 and the state is IDLE; the next cfg_commit sets cfg_err.
// - Load and commit: clb0 input0 code 1, all else 0; single_in=8'h01 -> clb0_input=6'h01 only after cfg_done. Before that it is 0.
// - Code bounds: clb1 input2 code 20 selects clb0_output[0]; toggling it follows. Code 21 or 31 -> 0.
// - Drivers: clb0 out0 single enables 2'b11, clb1 out0 single enables 2'b01 -> single_oe=8'h07.
//   - With clb0_output=0 and clb1_output=1: single_drv=8'h04.
// - Protocol: a 69th cfg_valid -> cfg_err=1 and the shadow is unchanged; commit at count 67 -> cfg_err=1 and the active config is unchanged.
// - Readback: shift 68 bits of pattern P and then 68 more of zeros -> cfg_out replays P in order. Carry wires pass through.

Source files
------------

// File: rtl/connection_block_cfg_pkg.sv
// Shared types and helpers for the connection block configuration slice.
package connection_block_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } cb_state_e;

  // Elaboration-time ceil(log2(v)); only ever called with constants.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cb_input_mux.sv
// One CLB input selector: code 0 and out-of-range codes give 0, code c gives src[c-1].
module cb_input_mux
  import connection_block_cfg_pkg::*;
#(
  parameter int N_IN  = 20,
  parameter int SEL_W = 5
) (
  input  logic [N_IN-1:0]  src,
  input  logic [SEL_W-1:0] sel,
  output logic             y
);

  always_comb begin
    y = 1'b0;
    for (int c = 1; c <= N_IN; c++) begin
      if (sel == SEL_W'(c)) y = src[c-1];
    end
  end

endmodule

// File: rtl/connection_block_cfg.sv
// Connection block between two CLBs with directional muxes/enables and a
// serially loaded shadow configuration committed atomically into the active copy.
module connection_block_cfg
  import connection_block_cfg_pkg::*;
#(
  parameter int WS         = 8,
  parameter int WD         = 8,
  parameter int WG         = 3,
  parameter int CLBIN      = 6,
  parameter int CLBOUT     = 1,
  parameter int CLBOS      = 2,
  parameter int CLBOD      = 2,
  parameter int CLBOS_BIAS = 0,
  parameter int CLBOD_BIAS = 0,
  parameter int CLBX       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic              cfg_in,
  input  logic              cfg_commit,
  output logic              cfg_out,
  output logic              cfg_ready,
  output logic              cfg_done,
  output logic              cfg_err,
  input  logic [WS-1:0]     single_in,
  input  logic [WD-1:0]     double_in,
  input  logic [WG-1:0]     global_in,
  input  logic [CLBOUT-1:0] clb0_output,
  input  logic [CLBOUT-1:0] clb1_output,
  input  logic              clb0_cout,
  input  logic              clb1_cout,
  output logic [CLBIN-1:0]  clb0_input,
  output logic [CLBIN-1:0]  clb1_input,
  output logic              clb0_cin,
  output logic              clb1_cin,
  output logic [WS-1:0]     single_drv,
  output logic [WS-1:0]     single_oe,
  output logic [WD-1:0]     double_drv,
  output logic [WD-1:0]     double_oe
);

  localparam int N_IN    = WS + WD + WG + CLBX * CLBOUT;
  localparam int SEL_W   = clog2(N_IN + 1);
  localparam int SPO     = CLBOS + CLBOD;
  localparam int HALF    = CLBIN * SEL_W + CLBOUT * SPO;
  localparam int CFG_LEN = 2 * HALF;
  localparam int CNT_W   = clog2(CFG_LEN + 1);
  localparam int DH      = WD / 2;
  localparam int S_OFF   = CLBOS_BIAS * CLBOS * 2 * CLBOUT;
  localparam int D_OFF   = CLBOD_BIAS * CLBOD * 2 * CLBOUT;
  localparam int NSRC    = 2 * CLBOUT;

  cb_state_e          state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CFG_LEN-1:0] shadow, active;
  logic               shift_en, commit_go, err_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // cfg_start wins over everything else in the same cycle and never flags an error.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_en  = 1'b0;
    commit_go = 1'b0;
    err_set   = 1'b0;
    if (cfg_start) begin
      state_nxt = LOAD;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          shift_en = cfg_valid;
          err_set  = cfg_commit;
        end
        LOAD: begin
          err_set = cfg_commit;
          if (cfg_valid) begin
            shift_en = 1'b1;
            cnt_nxt  = cnt + CNT_W'(1);
            if (cnt == CNT_W'(CFG_LEN - 1)) state_nxt = READY;
          end
        end
        READY: begin
          err_set = cfg_valid;
          if (cfg_commit) begin
            commit_go = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      shadow   <= '0;
      active   <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      cfg_done <= commit_go;
      if (shift_en)  shadow  <= {shadow[CFG_LEN-2:0], cfg_in};
      if (commit_go) active  <= shadow;
      if (err_set)   cfg_err <= 1'b1;
    end
  end

  assign cfg_out   = shadow[CFG_LEN-1];
  assign cfg_ready = (state == READY);

  assign clb1_cin = clb0_cout;
  assign clb0_cin = clb1_cout;

  // Source order seen by the muxes: singles, doubles, globals, other CLB's outputs.
  logic [N_IN-1:0] src0, src1;
  generate
    if (CLBX != 0) begin : g_cross
      assign src0 = {clb1_output, global_in, double_in, single_in};
      assign src1 = {clb0_output, global_in, double_in, single_in};
    end else begin : g_nocross
      assign src0 = {global_in, double_in, single_in};
      assign src1 = {global_in, double_in, single_in};
    end
  endgenerate

  for (genvar i = 0; i < CLBIN; i++) begin : g_in
    cb_input_mux #(.N_IN(N_IN), .SEL_W(SEL_W)) u_mux0 (
      .src (src0),
      .sel (active[i*SEL_W +: SEL_W]),
      .y   (clb0_input[i])
    );
    cb_input_mux #(.N_IN(N_IN), .SEL_W(SEL_W)) u_mux1 (
      .src (src1),
      .sel (active[HALF + i*SEL_W +: SEL_W]),
      .y   (clb1_input[i])
    );
  end

  // Source j = s*CLBOUT + k; flattened enables keep the track loops simple.
  logic [NSRC-1:0]       clb_out_all;
  logic [NSRC*CLBOS-1:0] sen;
  logic [NSRC*CLBOD-1:0] den;

  assign clb_out_all = {clb1_output, clb0_output};

  for (genvar j = 0; j < NSRC; j++) begin : g_en
    localparam int EB = (j / CLBOUT) * HALF + CLBIN * SEL_W + (j % CLBOUT) * SPO;
    assign sen[j*CLBOS +: CLBOS] = active[EB +: CLBOS];
    assign den[j*CLBOD +: CLBOD] = active[EB + CLBOS +: CLBOD];
  end

  // Scanning sources high to low lets the lowest enabled (s,k) set drv last.
  for (genvar t = 0; t < WS; t++) begin : g_single
    logic oe_t, drv_t;
    always_comb begin
      oe_t  = 1'b0;
      drv_t = 1'b0;
      for (int j = NSRC - 1; j >= 0; j--) begin
        for (int b = CLBOS - 1; b >= 0; b--) begin
          if (((j * CLBOS + b + S_OFF) % WS) == t && sen[j*CLBOS + b]) begin
            oe_t  = 1'b1;
            drv_t = clb_out_all[j];
          end
        end
      end
    end
    assign single_oe[t]  = oe_t;
    assign single_drv[t] = drv_t;
  end

  for (genvar t = 0; t < WD; t++) begin : g_double
    if (t < DH) begin : g_drivable
      logic oe_t, drv_t;
      always_comb begin
        oe_t  = 1'b0;
        drv_t = 1'b0;
        for (int j = NSRC - 1; j >= 0; j--) begin
          for (int b = CLBOD - 1; b >= 0; b--) begin
            if (((j * CLBOD + b + D_OFF) % DH) == t && den[j*CLBOD + b]) begin
              oe_t  = 1'b1;
              drv_t = clb_out_all[j];
            end
          end
        end
      end
      assign double_oe[t]  = oe_t;
      assign double_drv[t] = drv_t;
    end else begin : g_upper
      assign double_oe[t]  = 1'b0;
      assign double_drv[t] = 1'b0;
    end
  end

endmodule

// File: tb/tb_connection_block_cfg.sv
// Directed bench for connection_block_cfg at default parameters (CFG_LEN = 68).
module tb_connection_block_cfg;

  localparam int CFG_LEN = 68;
  localparam int HALF    = 34;
  localparam int SEL_W   = 5;
  localparam int EN_BASE = 30;
  localparam int SPO     = 4;

  logic       clk, rst;
  logic       cfg_start, cfg_valid, cfg_in, cfg_commit;
  logic       cfg_out, cfg_ready, cfg_done, cfg_err;
  logic [7:0] single_in, double_in;
  logic [2:0] global_in;
  logic [0:0] clb0_output, clb1_output;
  logic       clb0_cout, clb1_cout, clb0_cin, clb1_cin;
  logic [5:0] clb0_input, clb1_input;
  logic [7:0] single_drv, single_oe, double_drv, double_oe;

  int n_chk  = 0;
  int n_fail = 0;

  logic [CFG_LEN-1:0] cfg, cfg_b, pat, got;

  connection_block_cfg dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_start   (cfg_start),
    .cfg_valid   (cfg_valid),
    .cfg_in      (cfg_in),
    .cfg_commit  (cfg_commit),
    .cfg_out     (cfg_out),
    .cfg_ready   (cfg_ready),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err),
    .single_in   (single_in),
    .double_in   (double_in),
    .global_in   (global_in),
    .clb0_output (clb0_output),
    .clb1_output (clb1_output),
    .clb0_cout   (clb0_cout),
    .clb1_cout   (clb1_cout),
    .clb0_input  (clb0_input),
    .clb1_input  (clb1_input),
    .clb0_cin    (clb0_cin),
    .clb1_cin    (clb1_cin),
    .single_drv  (single_drv),
    .single_oe   (single_oe),
    .double_drv  (double_drv),
    .double_oe   (double_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CFG_LEN-1:0] with_sel(input logic [CFG_LEN-1:0] c, input int s,
                                                   input int i, input int code);
    c[s*HALF + i*SEL_W +: SEL_W] = 5'(code);
    return c;
  endfunction

  function automatic logic [CFG_LEN-1:0] with_en(input logic [CFG_LEN-1:0] c, input int s,
                                                  input int k, input logic [3:0] en);
    c[s*HALF + EN_BASE + k*SPO +: SPO] = en;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    cfg_valid = 1'b1;
    cfg_in    = b;
    tick();
    cfg_valid = 1'b0;
    cfg_in    = 1'b0;
  endtask

  // Sends the top n bits of v, MSB first, so a full send leaves shadow == v.
  task automatic shift_bits(input logic [CFG_LEN-1:0] v, input int n);
    for (int i = CFG_LEN - 1; i >= CFG_LEN - n; i--) shift_bit(v[i]);
  endtask

  task automatic start_load();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic load(input logic [CFG_LEN-1:0] v);
    start_load();
    shift_bits(v, CFG_LEN);
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    rst = 1'b1;
    cfg_start = 0; cfg_valid = 0; cfg_in = 0; cfg_commit = 0;
    single_in = 0; double_in = 0; global_in = 0;
    clb0_output = 0; clb1_output = 0; clb0_cout = 0; clb1_cout = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", cfg_ready, 0);
    check("rst_done", cfg_done, 0);
    check("rst_err", cfg_err, 0);
    check("rst_cfg_out", cfg_out, 0);
    check("rst_clb0_in", clb0_input, 0);
    check("rst_single_oe", single_oe, 0);
    check("rst_double_oe", double_oe, 0);
    rst = 1'b0;

    // Non-zero active config, then reset in the middle of a load.
    cfg = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 6; i++) cfg = with_sel(cfg, s, i, 1);
      cfg = with_en(cfg, s, 0, 4'hF);
    end
    single_in = 8'hFF;
    load(cfg);
    commit();
    check("full_clb0_in", clb0_input, 6'h3F);
    check("full_clb1_in", clb1_input, 6'h3F);
    check("full_single_oe", single_oe, 8'h0F);
    check("full_double_oe", double_oe, 8'h0F);
    for (int i = 0; i < CFG_LEN; i++) shift_bit(1'b1);
    check("idle_shift_cfg_out", cfg_out, 1);
    start_load();
    for (int i = 0; i < 5; i++) shift_bit(1'b1);
    rst = 1'b1;
    #1;
    check("midrst_cfg_out", cfg_out, 0);
    check("midrst_ready", cfg_ready, 0);
    check("midrst_clb0_in", clb0_input, 0);
    check("midrst_clb1_in", clb1_input, 0);
    check("midrst_single_oe", single_oe, 0);
    check("midrst_single_drv", single_drv, 0);
    check("midrst_double_oe", double_oe, 0);
    rst = 1'b0;
    commit();
    check("midrst_commit_err", cfg_err, 1);
    check("midrst_commit_done", cfg_done, 0);

    // Load and commit: clb0 input0 <- single[0].
    do_reset();
    check("err_cleared", cfg_err, 0);
    single_in = 8'h01;
    load(with_sel('0, 0, 0, 1));
    check("lc_ready", cfg_ready, 1);
    check("lc_before_commit", clb0_input, 0);
    commit();
    check("lc_done", cfg_done, 1);
    check("lc_clb0_in", clb0_input, 6'h01);
    check("lc_clb1_in", clb1_input, 0);
    check("lc_ready_after", cfg_ready, 0);
    tick();
    check("lc_done_pulse", cfg_done, 0);

    // Selector code bounds on clb1 input2.
    single_in = 8'hFF; double_in = 8'hFF; global_in = 3'h7;
    clb0_output = 0; clb1_output = 1;
    load(with_sel('0, 1, 2, 20));
    commit();
    check("code20_lo", clb1_input, 0);
    clb0_output = 1;
    #1;
    check("code20_hi", clb1_input, 6'h04);
    clb0_output = 0;
    #1;
    check("code20_lo2", clb1_input, 0);
    clb0_output = 1;
    load(with_sel('0, 1, 2, 21));
    commit();
    check("code21", clb1_input, 0);
    load(with_sel('0, 1, 2, 31));
    commit();
    check("code31", clb1_input, 0);
    global_in = 3'b100;
    load(with_sel('0, 1, 2, 19));
    commit();
    check("code19_hi", clb1_input, 6'h04);
    global_in = 3'b011;
    #1;
    check("code19_lo", clb1_input, 0);
    double_in = 8'hFE;
    load(with_sel('0, 1, 2, 9));
    commit();
    check("code9_lo", clb1_input, 0);
    double_in = 8'h01;
    #1;
    check("code9_hi", clb1_input, 6'h04);

    // Track drivers.
    clb0_output = 0; clb1_output = 1;
    load(with_en(with_en('0, 0, 0, 4'b1011), 1, 0, 4'b0101));
    commit();
    check("drv_single_oe", single_oe, 8'h07);
    check("drv_single_drv", single_drv, 8'h04);
    check("drv_double_oe", double_oe, 8'h06);
    check("drv_double_drv", double_drv, 8'h04);
    clb0_output = 1; clb1_output = 0;
    #1;
    check("drv_single_drv2", single_drv, 8'h03);
    check("drv_double_drv2", double_drv, 8'h02);

    // Protocol: 69th cfg_valid is dropped and flagged.
    do_reset();
    single_in = 8'h02;
    cfg = with_sel('0, 0, 1, 2);
    load(cfg);
    check("p69_err_before", cfg_err, 0);
    check("p69_ready", cfg_ready, 1);
    shift_bit(1'b1);
    check("p69_err", cfg_err, 1);
    check("p69_still_ready", cfg_ready, 1);
    commit();
    check("p69_done", cfg_done, 1);
    check("p69_shadow_kept", clb0_input, 6'h02);

    // Protocol: commit one bit short is ignored and flagged.
    do_reset();
    single_in = 8'h03;
    load(cfg);
    commit();
    check("p67_base", clb0_input, 6'h02);
    cfg_b = with_sel('0, 0, 0, 1);
    start_load();
    shift_bits(cfg_b, CFG_LEN - 1);
    commit();
    check("p67_err", cfg_err, 1);
    check("p67_active_kept", clb0_input, 6'h02);
    check("p67_no_done", cfg_done, 0);
    check("p67_not_ready", cfg_ready, 0);
    shift_bit(cfg_b[0]);
    check("p67_ready_after_last", cfg_ready, 1);

    // Readback through cfg_out.
    do_reset();
    pat = 68'hA_5C3F_0E91_B7D2_6C48;
    for (int i = CFG_LEN - 1; i >= 0; i--) shift_bit(pat[i]);
    got = '0;
    for (int j = 0; j < CFG_LEN; j++) begin
      got[CFG_LEN-1-j] = cfg_out;
      shift_bit(1'b0);
    end
    check("readback", got, pat);
    check("readback_cfg_out_zero", cfg_out, 0);

    // Carry pass-through.
    clb0_cout = 1; clb1_cout = 0;
    #1;
    check("carry_c1", clb1_cin, 1);
    check("carry_c0", clb0_cin, 0);
    clb0_cout = 0; clb1_cout = 1;
    #1;
    check("carry_c1b", clb1_cin, 0);
    check("carry_c0b", clb0_cin, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
